// File: rtl/rtc_core.sv
// rtc_core -- real-time clock core.
//
// Purpose:
//    Counts clk cycles down to a one-second tick and keeps a binary
//    24-hour time (hour/minute/second). The time can be loaded directly,
//    nudged with manual hour/minute buttons, shown in 12-hour form, and
//    compared against an alarm time.
//
// Ports:
//    clk                     single clock; all state changes on its rising edge
//    rst                     synchronous, active-low reset
//    run                     1 = divider advances, 0 = divider and time hold
//    load                    level; writes load_hour/min/sec when all are in range
//    load_hour/min/sec       binary load values (5/6/6 bits)
//    inc_hour, inc_min       debounced manual-set buttons (rising-edge detected)
//    mode12                  1 = disp_hour shows 12-hour form
//    alarm_en                alarm enable
//    alarm_hour/min          alarm time (5/6 bits)
//    hour/minute/second      registered binary time, 24-hour form
//    disp_hour, pm           display hour and PM flag (combinational from hour)
//    sec_pulse               one-cycle strobe with each second advance
//    day_wrap                one-cycle strobe with 23:59:59 -> 00:00:00
//    alarm_hit               one-cycle strobe when a tick reaches alarm_hour:alarm_min:00

module rtc_core #(
   parameter int TICK_DIV = 100_000_000,
   parameter int DIV_W    = 27
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic       load,
   input  logic [4:0] load_hour,
   input  logic [5:0] load_min,
   input  logic [5:0] load_sec,
   input  logic       inc_hour,
   input  logic       inc_min,
   input  logic       mode12,
   input  logic       alarm_en,
   input  logic [4:0] alarm_hour,
   input  logic [5:0] alarm_min,
   output logic [4:0] hour,
   output logic [5:0] minute,
   output logic [5:0] second,
   output logic [4:0] disp_hour,
   output logic       pm,
   output logic       sec_pulse,
   output logic       day_wrap,
   output logic       alarm_hit
);

   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

   // state registers
   logic [DIV_W-1:0] r_div;
   logic [4:0]       r_hour;
   logic [5:0]       r_min;
   logic [5:0]       r_sec;
   logic             r_tick_pend;
   logic             r_inc_hour_q;
   logic             r_inc_min_q;
   logic             r_sec_pulse;
   logic             r_day_wrap;
   logic             r_alarm_hit;

   // next-state values
   logic [DIV_W-1:0] w_div_next;
   logic [4:0]       w_hour_next;
   logic [5:0]       w_min_next;
   logic [5:0]       w_sec_next;
   logic             w_pend_next;
   logic             w_sec_pulse_next;
   logic             w_day_wrap_next;
   logic             w_alarm_next;

   // decoded conditions
   logic             w_tick;
   logic             w_hour_edge;
   logic             w_min_edge;
   logic             w_load_ok;
   logic             w_advance;

   always_comb begin
      w_tick      = run && (r_div == DIV_MAX);
      w_hour_edge = inc_hour & ~r_inc_hour_q;
      w_min_edge  = inc_min & ~r_inc_min_q;
      w_load_ok   = load && (load_hour <= 5'd23) && (load_min <= 6'd59)
                         && (load_sec <= 6'd59);
      // a tick deferred by a button edge last cycle is served now
      w_advance   = w_tick | r_tick_pend;
   end

   always_comb begin
      w_div_next       = r_div;
      w_hour_next      = r_hour;
      w_min_next       = r_min;
      w_sec_next       = r_sec;
      w_pend_next      = r_tick_pend;
      w_sec_pulse_next = 1'b0;
      w_day_wrap_next  = 1'b0;
      w_alarm_next     = 1'b0;

      // divider: an accepted load restarts the second from zero
      if (w_load_ok) begin
         w_div_next = '0;
      end else if (run) begin
         w_div_next = w_tick ? '0 : r_div + DIV_W'(1);
      end

      if (w_load_ok) begin
         // load wins over buttons and ticks; any tick (new or pending) is lost
         w_hour_next = load_hour;
         w_min_next  = load_min;
         w_sec_next  = load_sec;
         w_pend_next = 1'b0;
      end else if (w_hour_edge || w_min_edge) begin
         if (w_hour_edge) begin
            w_hour_next = (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
         end
         if (w_min_edge) begin
            w_min_next = (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
            w_sec_next = 6'd0;
         end
         // defer a coincident tick by one cycle so no second is lost
         w_pend_next = r_tick_pend | w_tick;
      end else if (w_advance) begin
         w_pend_next      = 1'b0;
         w_sec_pulse_next = 1'b1;
         if (r_sec == 6'd59) begin
            w_sec_next = 6'd0;
            if (r_min == 6'd59) begin
               w_min_next = 6'd0;
               if (r_hour == 5'd23) begin
                  w_hour_next     = 5'd0;
                  w_day_wrap_next = 1'b1;
               end else begin
                  w_hour_next = r_hour + 5'd1;
               end
            end else begin
               w_min_next = r_min + 6'd1;
            end
         end else begin
            w_sec_next = r_sec + 6'd1;
         end
         // only tick-driven updates may fire the alarm
         w_alarm_next = alarm_en && (w_hour_next == alarm_hour)
                        && (w_min_next == alarm_min) && (w_sec_next == 6'd0);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_div        <= '0;
         r_hour       <= '0;
         r_min        <= '0;
         r_sec        <= '0;
         r_tick_pend  <= 1'b0;
         r_inc_hour_q <= 1'b0;
         r_inc_min_q  <= 1'b0;
         r_sec_pulse  <= 1'b0;
         r_day_wrap   <= 1'b0;
         r_alarm_hit  <= 1'b0;
      end else begin
         r_div        <= w_div_next;
         r_hour       <= w_hour_next;
         r_min        <= w_min_next;
         r_sec        <= w_sec_next;
         r_tick_pend  <= w_pend_next;
         // history always follows the buttons so a held level edges only once
         r_inc_hour_q <= inc_hour;
         r_inc_min_q  <= inc_min;
         r_sec_pulse  <= w_sec_pulse_next;
         r_day_wrap   <= w_day_wrap_next;
         r_alarm_hit  <= w_alarm_next;
      end
   end

   // 12-hour display: 0 -> 12, 13..23 -> 1..11
   always_comb begin
      disp_hour = r_hour;
      if (mode12) begin
         if (r_hour == 5'd0) begin
            disp_hour = 5'd12;
         end else if (r_hour > 5'd12) begin
            disp_hour = r_hour - 5'd12;
         end
      end
      pm = (r_hour >= 5'd12);
   end

   assign hour      = r_hour;
   assign minute    = r_min;
   assign second    = r_sec;
   assign sec_pulse = r_sec_pulse;
   assign day_wrap  = r_day_wrap;
   assign alarm_hit = r_alarm_hit;

endmodule

// File: doc/rtc_core.md
RTC_CORE -- requirements
Module: rtc_core

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100_000_000, giving clk cycles per second; legal range is 2 or more.
REQ-002 SHALL have parameter DIV_W, default 27, giving the divider counter width; the integrator guarantees 2^DIV_W >= TICK_DIV.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port run, input, 1 bit: when 1 the divider advances; when 0 the divider and time hold.
REQ-006 SHALL have port load, input, 1 bit: a level, sampled each cycle, that writes load_hour, load_min and load_sec.
REQ-007 SHALL have ports load_hour, load_min and load_sec, inputs, 5, 6 and 6 bits respectively, all binary.
REQ-008 SHALL have ports inc_hour and inc_min, inputs, 1 bit each: manual-set buttons, already debounced.
REQ-009 SHALL have port mode12, input, 1 bit: selects 12-hour display when 1.
REQ-010 SHALL have ports alarm_en, alarm_hour and alarm_min, inputs, 1, 5 and 6 bits respectively.
REQ-011 SHALL have ports hour, minute and second, outputs, 5, 6 and 6 bits respectively: the registered binary time in 24-hour form.
REQ-012 SHALL have ports disp_hour and pm, outputs, 5 and 1 bits respectively: the display hour and the PM flag.
REQ-013 SHALL have ports sec_pulse, day_wrap and alarm_hit, outputs, 1 bit each: single-cycle strobes.

Function
REQ-014 Divider SHALL count 0..TICK_DIV-1 while run=1; the internal tick is asserted in the cycle the divider holds TICK_DIV-1, and the divider then wraps to 0.
REQ-015 The cycle after a tick, second SHALL increment and sec_pulse SHALL be high for exactly one cycle.
REQ-016 Second SHALL wrap 59->0 with a carry to minute; minute SHALL wrap 59->0 with a carry to hour; hour SHALL wrap 23->0, and day_wrap SHALL pulse in the same cycle as 23:59:59->00:00:00.
REQ-017 Per-cycle priority SHALL be: reset, then load, then inc, then tick.
REQ-018 Load, when every field is in range (hour<=23, min<=59, sec<=59), SHALL write the time and clear the divider, with the new value visible the next cycle; a tick in that cycle is discarded.
REQ-019 Load with any field out of range SHALL be ignored entirely: time and divider unchanged, and the tick still processed.
REQ-020 inc_hour and inc_min SHALL be rising-edge detected internally; a held level gives exactly one increment.
REQ-021 An inc_hour edge SHALL apply hour+1 mod 24, with no day_wrap and minute/second untouched.
REQ-022 An inc_min edge SHALL apply minute+1 mod 60, with no carry into hour and second cleared to 0.
REQ-023 Simultaneous inc_hour and inc_min edges SHALL both apply in one cycle.
REQ-024 A tick coinciding with an inc edge SHALL be held pending and applied the following cycle; a pending tick SHALL be dropped if load is accepted in that cycle.
REQ-025 disp_hour SHALL equal hour when mode12=0; when mode12=1 it SHALL map 0->12, 1..12 unchanged, and 13..23->hour-12.
REQ-026 pm SHALL be 1 when hour>=12, independent of mode12; disp_hour and pm are combinational from the hour register.
REQ-027 alarm_hit SHALL pulse for one cycle when a tick-driven update produces hour=alarm_hour, minute=alarm_min, second=0 while alarm_en=1.
REQ-028 Load or inc reaching the alarm time SHALL NOT assert alarm_hit.

Reset
REQ-029 While rst=0 at a clk edge, the block SHALL set hour, minute, second and the divider to 0, clear the pending-tick and edge-detect history, and drive sec_pulse, day_wrap and alarm_hit to 0.
REQ-030 Outputs immediately after reset SHALL be disp_hour=0 when mode12=0 or 12 when mode12=1, and pm=0.
REQ-031 Reset SHALL abort any pending tick or load mid-operation; counting resumes from 0 on the first cycle with rst=1 and run=1.

Verification (TICK_DIV=4)
REQ-032 Bench SHALL check: reset, then run=1 for 240 cycles -> 60 sec_pulse strobes 4 cycles apart, and time reads 00:01:00.
REQ-033 Bench SHALL check: load 23:59:58, run 8 cycles -> 23:59:59 then 00:00:00, with one day_wrap coincident with the 00:00:00 update.
REQ-034 Bench SHALL check: load 25:10:10 -> ignored and time unchanged; load 13:05:07 with mode12=1 -> disp_hour=1, pm=1.
REQ-035 Bench SHALL check: at 10:59:30, hold inc_min high for 10 cycles -> 10:00:00 with exactly one increment and hour unchanged; then an inc_hour edge -> 11:00:00.
REQ-036 Bench SHALL check: alarm 07:30 with alarm_en=1, load 07:29:59, run -> alarm_hit one cycle at 07:30:00; a later load of 07:30:00 gives no alarm_hit.
REQ-037 Bench SHALL check: inc_min edge in a tick cycle -> second advances one cycle later, with no lost second; rst=0 mid-count -> all outputs 0 the next cycle.
